// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg
//   Shared definitions for the stopwatch controller slice: FSM state
//   encoding, the saturation value of the 6-digit BCD counter chain and
//   the default timing constants for the 50 MHz board.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  localparam logic [23:0] BCD_MAX = 24'h999999;

  // 10 ms count tick and 20 ms debounce window at 50 MHz
  localparam int unsigned TICK_DIV_DEF     = 32'd500000;
  localparam int unsigned DEBOUNCE_CNT_DEF = 32'd1000000;

  // Time advances in RUN and in LAP (the lap only freezes the display).
  function automatic logic is_running(input sw_state_e st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
//   Connection between the controller and the counter/display datapath.
//   cnt_en    : one-cycle count tick to the least-significant decade counter
//   cnt_clr   : one-cycle synchronous clear to every decade counter
//   count_bcd : live 6-digit BCD count, [23:20] most significant
//   disp_bcd  : value handed to the segment decoders
//   master = controller side, slave = counter chain / display side.
interface stopwatch_ctrl_if;
  logic        cnt_en;
  logic        cnt_clr;
  logic [23:0] count_bcd;
  logic [23:0] disp_bcd;

  modport master (output cnt_en, output cnt_clr, output disp_bcd, input count_bcd);
  modport slave  (input cnt_en, input cnt_clr, input disp_bcd, output count_bcd);
endinterface

// File: rtl/stopwatch_ctrl_key_debounce.sv
// key_debounce
//   Synchronises one raw active-low push-button and accepts a new level
//   only after DEBOUNCE_CNT consecutive samples that differ from the
//   currently accepted level. An accepted press (high->low) produces a
//   single-cycle press_p; releases produce nothing.
//   Ports: clk, rst_n (async, active-low), key_n (raw key), press_p (pulse).
module key_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 32'd1);

  logic [1:0]    sync_r;   // sync_r[1] is the synchronised level
  logic          level_r;  // accepted level, 1 = released
  logic [CW-1:0] cnt_r;    // run length of samples differing from level_r
  logic          press_r;

  // Synchroniser, stability counter and press-pulse generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= 2'b11;
      level_r <= 1'b1;
      cnt_r   <= {CW{1'b0}};
      press_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], key_n};
      press_r <= 1'b0;
      if (sync_r[1] == level_r) begin
        // any return to the accepted level restarts the stability window
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync_r[1];
        cnt_r   <= {CW{1'b0}};
        press_r <= ~sync_r[1];
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign press_p = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Run/pause/lap/reset controller for the 6-digit BCD stopwatch.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   key_ss_n, key_lr_n  : raw start/stop and lap/reset keys (active low)
//   bus (master)        : cnt_en / cnt_clr to the counter chain, count_bcd
//                         from it, disp_bcd to the segment decoders
//   run_led, lap_led    : status LEDs decoded from the registered state
//   state               : IDLE=0, RUN=1, LAP=2, PAUSE=3
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_ss_n,
  input  logic                    key_lr_n,
  stopwatch_ctrl_if.master        bus,
  output logic                    run_led,
  output logic                    lap_led,
  output logic [1:0]              state
);

  localparam int unsigned PW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 32'd1);

  logic        ss_p_s;
  logic        lr_p_s;
  sw_state_e   state_r;
  sw_state_e   state_nxt_s;
  logic [PW-1:0] presc_r;
  logic        cnt_en_r;
  logic        cnt_clr_r;
  logic [23:0] lap_r;
  logic        tick_due_s;
  logic        sat_s;
  logic        clr_s;
  logic        cap_s;
  logic        advance_s;

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_ss_n),
    .press_p (ss_p_s)
  );

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_lr (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_lr_n),
    .press_p (lr_p_s)
  );

  // Next-state, clear and lap-capture decode
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    cap_s       = 1'b0;
    tick_due_s  = is_running(state_r) && (presc_r == PRESC_LAST);
    // a tick that would roll 999999 over to 000000 stops the watch instead
    sat_s       = tick_due_s && (bus.count_bcd == BCD_MAX);
    if (sat_s) begin
      state_nxt_s = ST_PAUSE;
    end else if (ss_p_s) begin
      // start/stop wins over a coincident lap/reset press
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_RUN;
        ST_RUN:   state_nxt_s = ST_PAUSE;
        ST_LAP:   state_nxt_s = ST_PAUSE;
        ST_PAUSE: state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else if (lr_p_s) begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
          clr_s       = 1'b1;
        end
        ST_RUN: begin
          state_nxt_s = ST_LAP;
          cap_s       = 1'b1;
        end
        ST_LAP:   state_nxt_s = ST_RUN;
        ST_PAUSE: begin
          state_nxt_s = ST_IDLE;
          clr_s       = 1'b1;
        end
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    // the prescaler only moves on cycles that stay running, so a tick can
    // never land in IDLE/PAUSE and the partial period survives a pause
    advance_s = is_running(state_r) && is_running(state_nxt_s);
  end

  // State, prescaler, tick/clear strobes and lap register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      presc_r   <= {PW{1'b0}};
      cnt_en_r  <= 1'b0;
      cnt_clr_r <= 1'b0;
      lap_r     <= 24'h000000;
    end else begin
      state_r   <= state_nxt_s;
      cnt_clr_r <= clr_s;
      if (clr_s) begin
        lap_r <= 24'h000000;
      end else if (cap_s) begin
        lap_r <= bus.count_bcd;
      end else begin
        lap_r <= lap_r;
      end
      if (clr_s) begin
        presc_r  <= {PW{1'b0}};
        cnt_en_r <= 1'b0;
      end else if (advance_s) begin
        if (presc_r == PRESC_LAST) begin
          presc_r  <= {PW{1'b0}};
          cnt_en_r <= 1'b1;
        end else begin
          presc_r  <= presc_r + PW'(1);
          cnt_en_r <= 1'b0;
        end
      end else begin
        cnt_en_r <= 1'b0;
      end
    end
  end

  assign bus.cnt_en   = cnt_en_r;
  assign bus.cnt_clr  = cnt_clr_r;
  assign bus.disp_bcd = (state_r == ST_LAP) ? lap_r : bus.count_bcd;
  assign run_led      = is_running(state_r);
  assign lap_led      = (state_r == ST_LAP);
  assign state        = state_r;

endmodule
